// File: rtl/mem_req_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single shared memory bus.
// One transaction in flight at a time; D-side wins ties unless I-side has starved.
module mem_req_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic        dreq_is_write,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        oreq_valid,
    output logic        oreq_is_write,
    output logic [63:0] oreq_addr,
    output logic [2:0]  oreq_size,
    output logic [7:0]  oreq_strobe,
    output logic [63:0] oreq_data,
    input  logic        oresp_ready,
    input  logic        oresp_last,
    input  logic [63:0] oresp_data
);

    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    typedef struct packed {
        logic        isWrite;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } busReq_t;

    state_t        state, stateNext;
    logic [CW-1:0] starveCnt;
    busReq_t       reqBuf;
    logic          iReq, dReq, grantI, grantD, done;
    logic          iOk, dOk;
    logic [31:0]   iData;
    logic [63:0]   dData;

    // A side whose data_ok is pulsing this cycle may still show its old
    // valid; it must not be re-granted off that stale request.
    always_comb begin
        iReq      = ireq_valid & ~iOk;
        dReq      = dreq_valid & ~dOk;
        done      = oresp_ready & oresp_last;
        grantI    = 1'b0;
        grantD    = 1'b0;
        stateNext = state;
        case (state)
            IDLE: begin
                if (iReq && dReq) begin
                    if (starveCnt == CNT_MAX) grantI = 1'b1;
                    else                      grantD = 1'b1;
                end else if (iReq) begin
                    grantI = 1'b1;
                end else if (dReq) begin
                    grantD = 1'b1;
                end
                if (grantI)      stateNext = I_BUSY;
                else if (grantD) stateNext = D_BUSY;
            end
            I_BUSY, D_BUSY: begin
                if (done) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            starveCnt <= '0;
        end else begin
            state <= stateNext;
            if (grantI)
                starveCnt <= '0;
            else if (grantD && ireq_valid && starveCnt != CNT_MAX)
                starveCnt <= starveCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reqBuf <= '0;
        end else if (grantI) begin
            reqBuf.isWrite <= 1'b0;
            reqBuf.addr    <= ireq_addr;
            reqBuf.size    <= 3'b010;
            reqBuf.strobe  <= '0;
            reqBuf.data    <= '0;
        end else if (grantD) begin
            reqBuf.isWrite <= dreq_is_write;
            reqBuf.addr    <= dreq_addr;
            reqBuf.size    <= dreq_size;
            reqBuf.strobe  <= dreq_strobe;
            reqBuf.data    <= dreq_data;
        end
    end

    // Fetches return a 32-bit word picked from the 64-bit beat by addr[2].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iOk   <= 1'b0;
            dOk   <= 1'b0;
            iData <= '0;
            dData <= '0;
        end else begin
            iOk <= (state == I_BUSY) && done;
            dOk <= (state == D_BUSY) && done;
            if (state == I_BUSY && done)
                iData <= reqBuf.addr[2] ? oresp_data[63:32] : oresp_data[31:0];
            if (state == D_BUSY && done)
                dData <= oresp_data;
        end
    end

    assign oreq_valid    = (state != IDLE);
    assign oreq_is_write = reqBuf.isWrite;
    assign oreq_addr     = reqBuf.addr;
    assign oreq_size     = reqBuf.size;
    assign oreq_strobe   = reqBuf.strobe;
    assign oreq_data     = reqBuf.data;

    assign iresp_data_ok = iOk;
    assign iresp_data    = iData;
    assign dresp_data_ok = dOk;
    assign dresp_data    = dData;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus random traffic against
// a transaction-level model of the arbitration and response rules.
module tb_mem_req_arbiter;
    localparam int LIMIT = 4;
    localparam logic [63:0] IADDR = 64'h1000;
    localparam logic [63:0] DADDR = 64'h2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid, iresp_data_ok;
    logic [63:0] ireq_addr;
    logic [31:0] iresp_data;
    logic        dreq_valid, dreq_is_write, dresp_data_ok;
    logic [63:0] dreq_addr, dreq_data, dresp_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic        oreq_valid, oreq_is_write;
    logic [63:0] oreq_addr, oreq_data;
    logic [2:0]  oreq_size;
    logic [7:0]  oreq_strobe;
    logic        oresp_ready, oresp_last;
    logic [63:0] oresp_data;

    always #5 clk = ~clk;

    mem_req_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_is_write(dreq_is_write), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .oreq_valid(oreq_valid), .oreq_is_write(oreq_is_write), .oreq_addr(oreq_addr),
        .oreq_size(oreq_size), .oreq_strobe(oreq_strobe), .oreq_data(oreq_data),
        .oresp_ready(oresp_ready), .oresp_last(oresp_last), .oresp_data(oresp_data)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: who owns the bus, how long I has waited, what is owed.
    int          mOwner;   // 0 none, 1 fetch, 2 data
    int          mStarve;
    logic        mIOk, mDOk;
    logic [31:0] mIData;
    logic [63:0] mDData;
    logic        mIsWrite;
    logic [63:0] mAddr, mData;
    logic [2:0]  mSize;
    logic [7:0]  mStrobe;

    task automatic modelReset();
        mOwner = 0; mStarve = 0; mIOk = 0; mDOk = 0; mIData = 0; mDData = 0;
        mIsWrite = 0; mAddr = 0; mData = 0; mSize = 0; mStrobe = 0;
    endtask

    // Apply the arbitration rules to the inputs of the current cycle, then clock.
    task automatic step();
        bit gi, gd, nI, nD;
        nI = 0; nD = 0;
        if (mOwner == 0) begin
            gi = ireq_valid && !mIOk;
            gd = dreq_valid && !mDOk;
            if (gi && gd) begin
                if (mStarve == LIMIT) gd = 0; else gi = 0;
            end
            if (gi) begin
                mOwner = 1; mStarve = 0;
                mIsWrite = 0; mAddr = ireq_addr; mSize = 3'd2; mStrobe = 0; mData = 0;
            end else if (gd) begin
                mOwner = 2;
                if (ireq_valid) mStarve = (mStarve + 1 > LIMIT) ? LIMIT : mStarve + 1;
                mIsWrite = dreq_is_write; mAddr = dreq_addr; mSize = dreq_size;
                mStrobe = dreq_strobe; mData = dreq_data;
            end
        end else if (oresp_ready && oresp_last) begin
            if (mOwner == 1) begin
                nI = 1;
                mIData = mAddr[2] ? oresp_data[63:32] : oresp_data[31:0];
            end else begin
                nD = 1;
                mDData = oresp_data;
            end
            mOwner = 0;
        end
        mIOk = nI; mDOk = nD;
        @(posedge clk); #1;
    endtask

    task automatic busIdle();
        oresp_ready = 0; oresp_last = 0; oresp_data = 0;
    endtask

    task automatic setD(input logic wr, input logic [63:0] a, input logic [2:0] sz,
                        input logic [7:0] st, input logic [63:0] d);
        dreq_valid = 1; dreq_is_write = wr; dreq_addr = a; dreq_size = sz;
        dreq_strobe = st; dreq_data = d;
    endtask

    // One arbitration round: both (or only D) request together from a quiet
    // IDLE; the loser withdraws. Returns the address the bus was granted.
    task automatic doRound(input bit withI, output logic [63:0] granted);
        ireq_valid = withI; ireq_addr = IADDR;
        setD(1'b0, DADDR, 3'd3, 8'h00, 64'h0);
        step();
        granted = oreq_addr;
        if (oreq_addr == IADDR) dreq_valid = 0; else ireq_valid = 0;
        step();
        oresp_ready = 1; oresp_last = 1; oresp_data = 64'h5A5A;
        step();
        busIdle(); ireq_valid = 0; dreq_valid = 0;
        step();
    endtask

    task automatic test_reset();
        reset = 0; ireq_valid = 0; ireq_addr = 0; dreq_valid = 0;
        dreq_is_write = 0; dreq_addr = 0; dreq_size = 0; dreq_strobe = 0; dreq_data = 0;
        busIdle();
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        oresp_ready = 1; oresp_last = 1; oresp_data = '1;
        @(posedge clk); #1;
        nChecks++; if (oreq_valid !== 1'b0) begin nFails++; $display("FAIL reset_oreq_valid got %0b want 0", oreq_valid); end
        nChecks++; if ({oreq_is_write, oreq_addr, oreq_size, oreq_strobe, oreq_data} !== '0) begin nFails++; $display("FAIL reset_oreq_fields got nonzero addr=%h data=%h", oreq_addr, oreq_data); end
        nChecks++; if ({iresp_data_ok, dresp_data_ok} !== 2'b00) begin nFails++; $display("FAIL reset_ok got %b want 00", {iresp_data_ok, dresp_data_ok}); end
        nChecks++; if (iresp_data !== 32'h0 || dresp_data !== 64'h0) begin nFails++; $display("FAIL reset_data got %h/%h want 0", iresp_data, dresp_data); end
        busIdle();
        reset = 1;
    endtask

    task automatic test_fetch();
        ireq_valid = 1; ireq_addr = 64'h8000_0004;
        step();
        nChecks++; if (oreq_valid !== 1'b1 || oreq_addr !== 64'h8000_0004) begin nFails++; $display("FAIL fetch_grant got v=%0b a=%h want 1/80000004", oreq_valid, oreq_addr); end
        nChecks++; if (oreq_is_write !== 1'b0 || oreq_size !== 3'b010 || oreq_strobe !== 8'h0 || oreq_data !== 64'h0) begin nFails++; $display("FAIL fetch_fields got w=%0b s=%0d st=%h", oreq_is_write, oreq_size, oreq_strobe); end
        step(); step();
        nChecks++; if (oreq_valid !== 1'b1 || iresp_data_ok !== 1'b0) begin nFails++; $display("FAIL fetch_wait got v=%0b ok=%0b want 1/0", oreq_valid, iresp_data_ok); end
        oresp_ready = 1; oresp_last = 1; oresp_data = 64'h11112222_33334444;
        step();
        busIdle();
        nChecks++; if (iresp_data_ok !== 1'b1 || dresp_data_ok !== 1'b0) begin nFails++; $display("FAIL fetch_ok got i=%0b d=%0b want 1/0", iresp_data_ok, dresp_data_ok); end
        nChecks++; if (iresp_data !== 32'h11112222) begin nFails++; $display("FAIL fetch_data got %h want 11112222", iresp_data); end
        ireq_valid = 0;
        step();
        nChecks++; if (iresp_data_ok !== 1'b0 || oreq_valid !== 1'b0) begin nFails++; $display("FAIL fetch_pulse got ok=%0b v=%0b want 0/0", iresp_data_ok, oreq_valid); end
    endtask

    task automatic test_simultaneous();
        ireq_valid = 1; ireq_addr = 64'h40;
        setD(1'b1, 64'h88, 3'd3, 8'hFF, 64'hCAFE);
        step();
        nChecks++; if (oreq_addr !== 64'h88 || oreq_is_write !== 1'b1) begin nFails++; $display("FAIL simul_d_first got a=%h w=%0b want 88/1", oreq_addr, oreq_is_write); end
        oresp_ready = 1; oresp_last = 1; oresp_data = 64'h0;
        step();
        busIdle();
        dreq_valid = 0;
        step();
        nChecks++; if (oreq_valid !== 1'b1 || oreq_addr !== 64'h40 || oreq_is_write !== 1'b0) begin nFails++; $display("FAIL simul_i_next got v=%0b a=%h want 1/40", oreq_valid, oreq_addr); end
        oresp_ready = 1; oresp_last = 1; oresp_data = 64'hAAAA_BBBB_CCCC_DDDD;
        step();
        busIdle(); ireq_valid = 0;
        nChecks++; if (iresp_data_ok !== 1'b1 || iresp_data !== 32'hCCCC_DDDD) begin nFails++; $display("FAIL simul_i_data got ok=%0b d=%h want 1/ccccdddd", iresp_data_ok, iresp_data); end
        step();
    endtask

    task automatic test_mask();
        ireq_valid = 0;
        setD(1'b0, 64'h300, 3'd2, 8'h0, 64'h0);
        step();
        oresp_ready = 1; oresp_last = 1; oresp_data = 64'h77;
        step();
        busIdle();
        nChecks++; if (dresp_data_ok !== 1'b1) begin nFails++; $display("FAIL mask_ok got %0b want 1", dresp_data_ok); end
        step();  // dreq_valid still high during the data_ok cycle
        nChecks++; if (oreq_valid !== 1'b0) begin nFails++; $display("FAIL mask_regrant got %0b want 0", oreq_valid); end
        dreq_valid = 0;
        step();
    endtask

    task automatic test_starvation();
        logic [63:0] g;
        for (int r = 0; r < LIMIT; r++) begin
            doRound(1'b1, g);
            nChecks++; if (g !== DADDR) begin nFails++; $display("FAIL starve_d_round%0d got %h want %h", r, g, DADDR); end
        end
        doRound(1'b1, g);
        nChecks++; if (g !== IADDR) begin nFails++; $display("FAIL starve_i_forced got %h want %h", g, IADDR); end
        doRound(1'b1, g);
        nChecks++; if (g !== DADDR) begin nFails++; $display("FAIL starve_cleared got %h want %h", g, DADDR); end
    endtask

    task automatic test_store();
        logic [31:0] iHeld;
        iHeld = iresp_data;
        ireq_valid = 0;
        setD(1'b1, 64'h900, 3'd2, 8'h0F, 64'hDEADBEEF);
        step();
        dreq_valid = 0; dreq_strobe = 8'hF0; dreq_data = 64'h0; dreq_addr = 64'h0;
        for (int k = 0; k < 3; k++) begin
            nChecks++; if (oreq_valid !== 1'b1 || oreq_strobe !== 8'h0F || oreq_data !== 64'hDEADBEEF || oreq_addr !== 64'h900) begin nFails++; $display("FAIL store_stable%0d got v=%0b st=%h d=%h", k, oreq_valid, oreq_strobe, oreq_data); end
            step();
        end
        oresp_ready = 1; oresp_last = 1; oresp_data = 64'h0;
        step();
        busIdle();
        nChecks++; if (dresp_data_ok !== 1'b1) begin nFails++; $display("FAIL store_ok got %0b want 1", dresp_data_ok); end
        nChecks++; if (iresp_data !== iHeld) begin nFails++; $display("FAIL store_i_hold got %h want %h", iresp_data, iHeld); end
        step();
        nChecks++; if (dresp_data_ok !== 1'b0) begin nFails++; $display("FAIL store_pulse got %0b want 0", dresp_data_ok); end
    endtask

    task automatic test_multibeat();
        int oks;
        oks = 0;
        ireq_valid = 0;
        setD(1'b0, 64'hA00, 3'd3, 8'h0, 64'h0);
        step();
        oresp_ready = 1; oresp_last = 0;
        for (int k = 0; k < 2; k++) begin
            oresp_data = 64'h1000 + 64'(k);
            step();
            oks += dresp_data_ok;
            nChecks++; if (oreq_valid !== 1'b1) begin nFails++; $display("FAIL beat%0d_busy got %0b want 1", k, oreq_valid); end
        end
        oresp_last = 1; oresp_data = 64'hFEED_F00D_1234_5678;
        step();
        busIdle();
        nChecks++; if (dresp_data !== 64'hFEED_F00D_1234_5678) begin nFails++; $display("FAIL beat_data got %h want feedf00d12345678", dresp_data); end
        oks += dresp_data_ok;
        dreq_valid = 0;
        for (int k = 0; k < 2; k++) begin step(); oks += dresp_data_ok; end
        nChecks++; if (oks !== 1) begin nFails++; $display("FAIL beat_okcount got %0d want 1", oks); end
        // bus activity while idle must leave everything untouched
        oresp_ready = 1; oresp_last = 1; oresp_data = 64'h9999;
        step(); step();
        busIdle();
        nChecks++; if (oreq_valid !== 1'b0 || dresp_data_ok !== 1'b0 || iresp_data_ok !== 1'b0 || dresp_data !== 64'hFEED_F00D_1234_5678) begin nFails++; $display("FAIL idle_ready got v=%0b ok=%0b%0b d=%h", oreq_valid, iresp_data_ok, dresp_data_ok, dresp_data); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] g;
        while (mStarve < LIMIT) doRound(1'b1, g);
        ireq_valid = 0;
        setD(1'b0, 64'hB00, 3'd3, 8'h0, 64'h0);
        step();
        nChecks++; if (oreq_valid !== 1'b1) begin nFails++; $display("FAIL rmid_busy got %0b want 1", oreq_valid); end
        #2;
        reset = 0; dreq_valid = 0;
        oresp_ready = 1; oresp_last = 1; oresp_data = 64'h4444;
        modelReset();
        #1;
        nChecks++; if (oreq_valid !== 1'b0) begin nFails++; $display("FAIL rmid_drop got %0b want 0", oreq_valid); end
        @(posedge clk); #1;
        reset = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            nChecks++; if (dresp_data_ok !== 1'b0 || oreq_valid !== 1'b0) begin nFails++; $display("FAIL rmid_quiet%0d got ok=%0b v=%0b want 0/0", k, dresp_data_ok, oreq_valid); end
        end
        busIdle();
        doRound(1'b1, g);
        nChecks++; if (g !== DADDR) begin nFails++; $display("FAIL rmid_cnt_clear got %h want %h", g, DADDR); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            nChecks++; if (oreq_valid !== (mOwner != 0)) begin nFails++; $display("FAIL rnd_valid c%0d got %0b want %0b", c, oreq_valid, mOwner != 0); end
            if (mOwner != 0) begin
                nChecks++; if ({oreq_is_write, oreq_addr, oreq_size, oreq_strobe, oreq_data} !== {mIsWrite, mAddr, mSize, mStrobe, mData}) begin nFails++; $display("FAIL rnd_fields c%0d got a=%h d=%h want a=%h d=%h", c, oreq_addr, oreq_data, mAddr, mData); end
            end
            nChecks++; if (iresp_data_ok !== mIOk || dresp_data_ok !== mDOk) begin nFails++; $display("FAIL rnd_ok c%0d got %0b%0b want %0b%0b", c, iresp_data_ok, dresp_data_ok, mIOk, mDOk); end
            nChecks++; if (iresp_data !== mIData || dresp_data !== mDData) begin nFails++; $display("FAIL rnd_data c%0d got %h/%h want %h/%h", c, iresp_data, dresp_data, mIData, mDData); end
            // requesters: hold until data_ok, then drop or issue a fresh request
            if (iresp_data_ok) begin
                ireq_valid = $urandom_range(1, 0) == 1;
                ireq_addr = {$urandom, $urandom};
            end else if (!ireq_valid && $urandom_range(9, 0) < 3) begin
                ireq_valid = 1; ireq_addr = {$urandom, $urandom};
            end
            if (dresp_data_ok) begin
                if ($urandom_range(1, 0) == 1) setD($urandom_range(1, 0) == 1, {$urandom, $urandom}, 3'($urandom_range(3, 0)), 8'($urandom), {$urandom, $urandom});
                else dreq_valid = 0;
            end else if (!dreq_valid && $urandom_range(9, 0) < 4) begin
                setD($urandom_range(1, 0) == 1, {$urandom, $urandom}, 3'($urandom_range(3, 0)), 8'($urandom), {$urandom, $urandom});
            end
            oresp_ready = $urandom_range(1, 0) == 1;
            oresp_last  = oresp_ready && ($urandom_range(2, 0) == 0);
            oresp_data  = {$urandom, $urandom};
            step();
        end
        busIdle(); ireq_valid = 0; dreq_valid = 0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_mask();
        test_starvation();
        test_store();
        test_multibeat();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
